// File: rtl/sync_fifo_plus.sv
// sync_fifo_plus: single-clock FIFO for any depth >= 2 with almost flags, sticky errors and peak watermark.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered (1-cycle latency).
module sync_fifo_plus #(
    parameter int  DATA_W = 16,
    parameter int  FIFO_D = 32,
    localparam int PTR_W  = $clog2(FIFO_D)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    input  logic [PTR_W:0]    af_thresh,
    input  logic [PTR_W:0]    ae_thresh,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [PTR_W:0]    room_avail,
    output logic [PTR_W:0]    data_avail,
    output logic [PTR_W:0]    peak_lvl,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(FIFO_D - 1);
    localparam logic [PTR_W:0]   DEPTH = {1'b0, LAST} + {{PTR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count, count_nxt;
    logic              wr_ok, rd_ok;

    // All status is derived from the count register alone.
    assign fifo_full    = (count == DEPTH);
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);
    assign room_avail   = DEPTH - count;
    assign data_avail   = count;

    assign wr_ok     = wr_en && !fifo_full;
    assign rd_ok     = rd_en && !fifo_empty;
    assign count_nxt = count + {{PTR_W{1'b0}}, wr_ok} - {{PTR_W{1'b0}}, rd_ok};

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // Explicit wrap compare keeps pointers legal for non-power-of-2 depths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            peak_lvl  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count     <= count_nxt;
            overflow  <= (overflow  && !err_clr) || (wr_en && fifo_full);
            underflow <= (underflow && !err_clr) || (rd_en && fifo_empty);
            if (err_clr)                     peak_lvl <= count_nxt;
            else if (count_nxt > peak_lvl)   peak_lvl <= count_nxt;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = fifo_empty ? '0 : mem[rd_ptr];
    assign rd_valid = !fifo_empty;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) rd_data <= mem[rd_ptr];
        end
    end
`endif

endmodule
